// File: rtl/rr_arb_8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Holds the state encoding, widths and the rotating-priority pick function.
package rr_arb_8_pkg;

  localparam int unsigned ARB_N     = 8;
  localparam int unsigned ARB_IDX_W = 3;
  localparam int unsigned HOLD_W    = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Scan from the highest offset down so the set bit closest to ptr is the
  // last assignment and therefore the winner.
  function automatic logic [ARB_IDX_W-1:0] rr_pick(
    input logic [ARB_N-1:0]     req_v,
    input logic [ARB_IDX_W-1:0] ptr
  );
    logic [ARB_IDX_W-1:0] win;
    logic [ARB_IDX_W-1:0] cand;
    win = ptr;
    for (int unsigned k = ARB_N; k > 0; k--) begin
      cand = ptr + ARB_IDX_W'(k - 1);
      if (req_v[cand]) win = cand;
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_arb_8_dec.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module dec_3x8
  import rr_arb_8_pkg::*;
(
  input  logic [ARB_IDX_W-1:0] in,
  input  logic                 E,
  output logic [ARB_N-1:0]     out
);

  always_comb begin
    out = '0;
    if (E) out[in] = 1'b1;
  end

endmodule

// File: rtl/rr_arb_8.sv
// Round-robin arbiter for 8 requesters with a per-grant hold limit.
// gnt is a combinational decode of the registered owner index, gated by busy.
module rr_arb_8
  import rr_arb_8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ARB_N-1:0]     req,
  input  logic                 done,
  output logic [ARB_N-1:0]     gnt,
  output logic [ARB_IDX_W-1:0] gnt_idx,
  output logic                 busy,
  output logic                 timeout
);

  localparam logic [HOLD_W-1:0] LP_MAX_HOLD = HOLD_W'(MAX_HOLD);

  arb_state_t           r_state, w_state;
  logic [ARB_IDX_W-1:0] r_idx,   w_idx;
  logic [ARB_IDX_W-1:0] r_ptr,   w_ptr;
  logic [HOLD_W-1:0]    r_hold,  w_hold;
  logic                 r_busy,  w_busy;
  logic                 r_tmo,   w_tmo;
  logic [ARB_IDX_W-1:0] w_win;
  logic                 w_any;

  assign w_win = rr_pick(req, r_ptr);
  assign w_any = |req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_busy  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_ptr   <= w_ptr;
      r_hold  <= w_hold;
      r_busy  <= w_busy;
      r_tmo   <= w_tmo;
    end
  end

  // A normal release (done or owner dropped req) outranks the hold limit,
  // so timeout only fires when the limit alone ends the grant.
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_ptr   = r_ptr;
    w_hold  = r_hold;
    w_busy  = r_busy;
    w_tmo   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state = ST_GRANT;
          w_idx   = w_win;
          w_busy  = 1'b1;
          w_hold  = HOLD_W'(1);
        end
      end
      ST_GRANT: begin
        if (done || !req[r_idx] || (r_hold == LP_MAX_HOLD)) begin
          w_state = ST_IDLE;
          w_busy  = 1'b0;
          w_ptr   = r_idx + 1'b1;
          w_tmo   = !(done || !req[r_idx]);
        end else begin
          w_hold  = r_hold + 1'b1;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign gnt_idx = r_idx;
  assign busy    = r_busy;
  assign timeout = r_tmo;

  dec_3x8 u_dec (
    .in  (r_idx),
    .E   (r_busy),
    .out (gnt)
  );

endmodule

// File: tb/tb_rr_arb_8.sv
// Scoreboard bench for rr_arb_8: stimulus queues expected grants, a monitor
// pops one per observed grant and checks owner, length, idle gap and timeout.
module tb_rr_arb_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    int         len;   // 0 = do not check
    bit         to;
    int         gap;   // 0 = do not check
  } exp_t;

  exp_t exp_q[$];

  rr_arb_8 #(.MAX_HOLD(15)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, act=running req=stopped");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic v, input int budget);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (busy === v) begin
        hit = 1'b1;
        break;
      end
      cyc();
    end
    if (!hit && busy === v) hit = 1'b1;
    chk("wait_busy", {31'd0, hit}, 32'd1);
  endtask

  task automatic push(input logic [7:0] g, input logic [2:0] i, input int len,
                      input bit to, input int gap);
    exp_t e;
    e.gnt = g; e.idx = i; e.len = len; e.to = to; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // One-cycle grant ended by done.
  task automatic grant_done(input logic [7:0] r, input logic [7:0] g,
                            input logic [2:0] i, input int gap);
    push(g, i, 1, 1'b0, gap);
    req = r;
    wait_busy(1'b1, 4);
    done = 1'b1;
    cyc();
    done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Monitor
  exp_t cur;
  bit   prev_busy = 1'b0;
  int   len_cnt = 0;
  int   gap_cnt = 0;

  always @(negedge clk) begin
    chk("onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
    if (!busy) chk("idle_gnt_zero", {24'd0, gnt}, 32'd0);
    if (busy && !prev_busy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_grant: actual gnt=%0h required=no grant", gnt);
        cur.gnt = gnt; cur.idx = gnt_idx; cur.len = 0; cur.to = 1'b0; cur.gap = 0;
      end else begin
        cur = exp_q.pop_front();
        chk("grant_gnt", {24'd0, gnt}, {24'd0, cur.gnt});
        chk("grant_idx", {29'd0, gnt_idx}, {29'd0, cur.idx});
        if (cur.gap != 0) chk("idle_gap", gap_cnt, cur.gap);
      end
      len_cnt = 1;
    end else if (busy) begin
      len_cnt++;
    end
    if (!busy && prev_busy) begin
      if (cur.len != 0) chk("grant_len", len_cnt, cur.len);
      chk("release_timeout", {31'd0, timeout}, {31'd0, cur.to});
      gap_cnt = 1;
    end else if (!busy) begin
      gap_cnt++;
      if (timeout !== 1'b0) chk("stray_timeout", {31'd0, timeout}, 32'd0);
    end
    prev_busy = busy;
  end

  initial begin
    #1;
    // 1: reset and idle
    do_reset();
    for (int c = 0; c < 5; c++) begin
      chk("rst_gnt",     {24'd0, gnt},     32'd0);
      chk("rst_busy",    {31'd0, busy},    32'd0);
      chk("rst_idx",     {29'd0, gnt_idx}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      cyc();
    end

    // 2: wrap of the pointer between requesters 0 and 7
    grant_done(8'h81, 8'h01, 3'd0, 0);
    grant_done(8'h81, 8'h80, 3'd7, 1);
    grant_done(8'h81, 8'h01, 3'd0, 1);
    req = 8'h00;
    cyc();
    cyc();

    // 3: full rotation from ptr=0
    do_reset();
    for (int i = 0; i < 9; i++)
      grant_done(8'hFF, 8'(1 << (i % 8)), 3'(i % 8), (i == 0) ? 0 : 1);
    req = 8'h00;
    cyc();
    cyc();

    // 4: hold limit on requester 2 (ptr=1 here)
    push(8'h04, 3'd2, 15, 1'b1, 0);
    push(8'h04, 3'd2, 1, 1'b0, 1);
    req = 8'h04;
    wait_busy(1'b1, 4);
    wait_busy(1'b0, 20);
    wait_busy(1'b1, 3);
    done = 1'b1;
    cyc();
    done = 1'b0;
    req  = 8'h00;
    cyc();
    cyc();

    // 5a: done coincides with the limit -> normal release
    push(8'h08, 3'd3, 15, 1'b0, 0);
    req = 8'h08;
    wait_busy(1'b1, 4);
    repeat (14) cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
    req  = 8'h00;
    cyc();
    cyc();

    // 5b: owner drops req mid-grant
    push(8'h10, 3'd4, 4, 1'b0, 0);
    req = 8'h10;
    wait_busy(1'b1, 4);
    repeat (3) cyc();
    req = 8'h00;
    cyc();
    chk("drop_req_busy", {31'd0, busy}, 32'd0);
    cyc();

    // 6: async reset mid-grant
    push(8'h20, 3'd5, 0, 1'b0, 0);
    req = 8'h20;
    wait_busy(1'b1, 4);
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    req   = 8'h00;
    #1;
    chk("async_rst_gnt",  {24'd0, gnt},  32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    grant_done(8'h21, 8'h01, 3'd0, 0);
    grant_done(8'h10, 8'h10, 3'd4, 1);
    req = 8'h00;
    cyc();
    cyc();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
